// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU memory-bus responder:
// FSM states, CPLD serial register addresses and status-word bit positions.
package mem_bus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_SER_RD,
    ST_SER_WR,
    ST_SER_WAIT,
    ST_DONE
  } state_e;

  localparam logic [31:0] SER_DATA_ADDR_DEF = 32'hBFD003F8;
  localparam logic [31:0] SER_STAT_ADDR_DEF = 32'hBFD003FC;

  // Status word: bit 0 = transmitter fully idle, bit 1 = receive data ready
  localparam int STAT_TX_IDLE_BIT  = 0;
  localparam int STAT_RX_READY_BIT = 1;

  localparam logic [3:0] SER_STROBE_CYCLES = 4'd2;

  function automatic logic is_sram_state(input state_e s);
    return (s == ST_RD) || (s == ST_WR_SETUP) || (s == ST_WR_PULSE) || (s == ST_WR_HOLD);
  endfunction

  function automatic logic is_wr_drive_state(input state_e s);
    return (s == ST_WR_SETUP) || (s == ST_WR_PULSE) || (s == ST_WR_HOLD);
  endfunction

endpackage

// File: rtl/mem_bus_responder_cycle_counter.sv
// 4-bit down-counter timing the multi-cycle bus states. Loaded with N-1 on
// state entry; `last` is high during the final cycle of the timed state.
module cycle_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       last
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == 4'd0);

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: arbitrates CPU fetch/data requests onto the base SRAM
// and the CPLD serial port (sharing data[7:0]), stalling the CPU until done.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W        = 20,
  parameter int unsigned RD_CYCLES     = 2,
  parameter int unsigned WR_CYCLES     = 2,
  parameter logic [31:0] SER_DATA_ADDR = SER_DATA_ADDR_DEF,
  parameter logic [31:0] SER_STAT_ADDR = SER_STAT_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_ce_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_data_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       mem_data_o,
  output logic              stall_o,
  inout  wire  [31:0]       base_ram_data,
  output logic [ADDR_W-1:0] base_ram_addr,
  output logic [3:0]        base_ram_be_n,
  output logic              base_ram_ce_n,
  output logic              base_ram_oe_n,
  output logic              base_ram_we_n,
  output logic              uart_rdn,
  output logic              uart_wrn,
  input  logic              uart_dataready,
  input  logic              uart_tbre,
  input  logic              uart_tsre
);

  localparam logic [3:0] RD_LOAD  = 4'(RD_CYCLES - 1);
  localparam logic [3:0] WR_LOAD  = 4'(WR_CYCLES - 1);
  localparam logic [3:0] SER_LOAD = SER_STROBE_CYCLES - 4'd1;

  state_e state_q, state_d;

  logic              fetch_q, fetch_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic [3:0]        be_n_q, be_n_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              rdn_q, rdn_d;
  logic              wrn_q, wrn_d;
  logic              drive_hi_q, drive_hi_d;
  logic              drive_lo_q, drive_lo_d;

  logic       cnt_load;
  logic [3:0] cnt_load_val;
  logic       cnt_last;

  logic        hit_data;
  logic        hit_stat;
  logic        tx_idle;
  logic [31:0] stat_word;
  logic        unused_addr_bits;

  assign hit_data = (mem_addr_i == SER_DATA_ADDR);
  assign hit_stat = (mem_addr_i == SER_STAT_ADDR);
  assign tx_idle  = uart_tbre & uart_tsre;

  always_comb begin
    stat_word                    = 32'd0;
    stat_word[STAT_TX_IDLE_BIT]  = tx_idle;
    stat_word[STAT_RX_READY_BIT] = uart_dataready;
  end

  assign unused_addr_bits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0]};

  cycle_counter u_cycle_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .last     (cnt_last)
  );

  // Next-state and operation capture
  always_comb begin
    state_d      = state_q;
    fetch_d      = fetch_q;
    sel_d        = sel_q;
    wdata_d      = wdata_q;
    addr_d       = addr_q;
    if_data_d    = if_data_q;
    mem_data_d   = mem_data_q;
    cnt_load     = 1'b0;
    cnt_load_val = 4'd0;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_ce_i) begin
          fetch_d = 1'b0;
          sel_d   = mem_sel_i;
          wdata_d = mem_data_i;
          if (hit_stat) begin
            state_d = ST_DONE;
            if (!mem_we_i) begin
              mem_data_d = stat_word;
            end
          end else if (hit_data) begin
            state_d      = mem_we_i ? ST_SER_WR : ST_SER_RD;
            cnt_load     = 1'b1;
            cnt_load_val = SER_LOAD;
          end else if (mem_we_i) begin
            state_d = ST_WR_SETUP;
            addr_d  = mem_addr_i[ADDR_W+1:2];
          end else begin
            state_d      = ST_RD;
            addr_d       = mem_addr_i[ADDR_W+1:2];
            cnt_load     = 1'b1;
            cnt_load_val = RD_LOAD;
          end
        end else if (if_ce_i) begin
          // Fetches always read the full word: all byte lanes enabled
          fetch_d      = 1'b1;
          sel_d        = 4'hF;
          addr_d       = if_addr_i[ADDR_W+1:2];
          state_d      = ST_RD;
          cnt_load     = 1'b1;
          cnt_load_val = RD_LOAD;
        end
      end
      ST_RD: begin
        if (cnt_last) begin
          state_d = ST_DONE;
          if (fetch_q) begin
            if_data_d = base_ram_data;
          end else begin
            mem_data_d = base_ram_data;
          end
        end
      end
      ST_WR_SETUP: begin
        state_d      = ST_WR_PULSE;
        cnt_load     = 1'b1;
        cnt_load_val = WR_LOAD;
      end
      ST_WR_PULSE: begin
        if (cnt_last) begin
          state_d = ST_WR_HOLD;
        end
      end
      ST_WR_HOLD: state_d = ST_DONE;
      ST_SER_RD: begin
        if (cnt_last) begin
          state_d    = ST_DONE;
          mem_data_d = {24'd0, base_ram_data[7:0]};
        end
      end
      ST_SER_WR: begin
        if (cnt_last) begin
          state_d = ST_SER_WAIT;
        end
      end
      ST_SER_WAIT: begin
        if (tx_idle) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin strobes are decoded from the next state and registered, so each one
  // is active exactly while the FSM sits in the matching state.
  always_comb begin
    ce_n_d     = ~is_sram_state(state_d);
    oe_n_d     = ~(state_d == ST_RD);
    we_n_d     = ~(state_d == ST_WR_PULSE);
    rdn_d      = ~(state_d == ST_SER_RD);
    wrn_d      = ~(state_d == ST_SER_WR);
    be_n_d     = is_sram_state(state_d) ? ~sel_d : 4'hF;
    drive_hi_d = is_wr_drive_state(state_d);
    drive_lo_d = is_wr_drive_state(state_d) | (state_d == ST_SER_WR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_q    <= 1'b0;
      sel_q      <= 4'd0;
      wdata_q    <= 32'd0;
      addr_q     <= '0;
      if_data_q  <= 32'd0;
      mem_data_q <= 32'd0;
      be_n_q     <= 4'hF;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      rdn_q      <= 1'b1;
      wrn_q      <= 1'b1;
      drive_hi_q <= 1'b0;
      drive_lo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_q    <= fetch_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      if_data_q  <= if_data_d;
      mem_data_q <= mem_data_d;
      be_n_q     <= be_n_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      rdn_q      <= rdn_d;
      wrn_q      <= wrn_d;
      drive_hi_q <= drive_hi_d;
      drive_lo_q <= drive_lo_d;
    end
  end

  // Gated by rst_n so the pipeline is released while reset is held
  assign stall_o = rst_n & ((state_q == ST_IDLE) ? (if_ce_i | mem_ce_i)
                                                 : (state_q != ST_DONE));

  assign base_ram_data[31:8] = drive_hi_q ? wdata_q[31:8] : 24'bz;
  assign base_ram_data[7:0]  = drive_lo_q ? wdata_q[7:0]  : 8'bz;

  assign if_data_o     = if_data_q;
  assign mem_data_o    = mem_data_q;
  assign base_ram_addr = addr_q;
  assign base_ram_be_n = be_n_q;
  assign base_ram_ce_n = ce_n_q;
  assign base_ram_oe_n = oe_n_q;
  assign base_ram_we_n = we_n_q;
  assign uart_rdn      = rdn_q;
  assign uart_wrn      = wrn_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed self-checking bench for mem_bus_responder: SRAM read/write, arbitration,
// serial read/write/status and asynchronous reset in the middle of a write.
module tb_mem_bus_responder;
  import mem_bus_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        stall_o;
  wire  [31:0] base_ram_data;
  logic [19:0] base_ram_addr;
  logic [3:0]  base_ram_be_n;
  logic        base_ram_ce_n;
  logic        base_ram_oe_n;
  logic        base_ram_we_n;
  logic        uart_rdn;
  logic        uart_wrn;
  logic        uart_dataready;
  logic        uart_tbre;
  logic        uart_tsre;

  // Bench-side model of the SRAM/CPLD driving the shared bus on reads
  logic        tb_bus_en;
  logic        tb_bus_by_addr;
  logic [31:0] tb_bus_fix;
  logic [31:0] tb_bus_val;

  assign tb_bus_val    = tb_bus_by_addr ? {12'hA5A, base_ram_addr} : tb_bus_fix;
  assign base_ram_data = tb_bus_en ? tb_bus_val : 32'bz;

  int n_checks = 0;
  int n_pass   = 0;

  int m_stall, m_ce, m_oe, m_we, m_rd, m_wr, m_drv_hi, m_drv_lo, m_overlap;
  int m_first_ce, m_first_we, m_first_wr, m_first_drv, m_last_drv;
  logic [31:0] m_bus;
  logic [19:0] m_addr;
  logic [3:0]  m_be;

  mem_bus_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_ce_i        (if_ce_i),
    .if_addr_i      (if_addr_i),
    .if_data_o      (if_data_o),
    .mem_ce_i       (mem_ce_i),
    .mem_we_i       (mem_we_i),
    .mem_addr_i     (mem_addr_i),
    .mem_sel_i      (mem_sel_i),
    .mem_data_i     (mem_data_i),
    .mem_data_o     (mem_data_o),
    .stall_o        (stall_o),
    .base_ram_data  (base_ram_data),
    .base_ram_addr  (base_ram_addr),
    .base_ram_be_n  (base_ram_be_n),
    .base_ram_ce_n  (base_ram_ce_n),
    .base_ram_oe_n  (base_ram_oe_n),
    .base_ram_we_n  (base_ram_we_n),
    .uart_rdn       (uart_rdn),
    .uart_wrn       (uart_wrn),
    .uart_dataready (uart_dataready),
    .uart_tbre      (uart_tbre),
    .uart_tsre      (uart_tsre)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Samples every stalled cycle (at negedge) until stall_o drops, tallying strobes
  task automatic measure(input string tag, input int limit);
    int  idx;
    bit  done;
    idx = 0; done = 1'b0;
    m_ce = 0; m_oe = 0; m_we = 0; m_rd = 0; m_wr = 0;
    m_drv_hi = 0; m_drv_lo = 0; m_overlap = 0;
    m_first_ce = -1; m_first_we = -1; m_first_wr = -1; m_first_drv = -1; m_last_drv = -1;
    m_bus = 32'd0; m_addr = 20'd0; m_be = 4'd0;
    while (!done && idx < limit) begin
      @(negedge clk);
      if (!stall_o) begin
        done = 1'b1;
      end else begin
        if (!base_ram_ce_n) begin
          if (m_first_ce < 0) m_first_ce = idx;
          m_ce++;
          m_addr = base_ram_addr;
          m_be   = base_ram_be_n;
        end
        if (!base_ram_oe_n) m_oe++;
        if (!base_ram_we_n) begin
          if (m_first_we < 0) m_first_we = idx;
          m_we++;
          m_bus = base_ram_data;
        end
        if (!uart_rdn) m_rd++;
        if (!uart_wrn) begin
          if (m_first_wr < 0) m_first_wr = idx;
          m_wr++;
          m_bus = base_ram_data;
        end
        if (dut.drive_hi_q) m_drv_hi++;
        if (dut.drive_lo_q) begin
          if (m_first_drv < 0) m_first_drv = idx;
          m_last_drv = idx;
          m_drv_lo++;
        end
        if (!base_ram_ce_n && (!uart_rdn || !uart_wrn)) m_overlap++;
        idx++;
      end
    end
    m_stall = idx;
    check({tag, " reached_done"}, 32'(done), 32'd1);
    $display("%s: stall=%0d ce=%0d oe=%0d we=%0d rdn=%0d wrn=%0d if_data=%h mem_data=%h",
             tag, m_stall, m_ce, m_oe, m_we, m_rd, m_wr, if_data_o, mem_data_o);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    if_ce_i  = 1'b0;
    mem_ce_i = 1'b0;
    mem_we_i = 1'b0;
  endtask

  logic [3:0] stat_vec [4];
  logic [31:0] stat_exp [4];

  initial begin
    rst_n = 1'b0;
    if_ce_i = 1'b0; if_addr_i = 32'd0;
    mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'd0; mem_sel_i = 4'd0; mem_data_i = 32'd0;
    uart_dataready = 1'b0; uart_tbre = 1'b1; uart_tsre = 1'b1;
    tb_bus_en = 1'b0; tb_bus_by_addr = 1'b0; tb_bus_fix = 32'd0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst ce_n", 32'(base_ram_ce_n), 32'd1);
    check("rst oe_n", 32'(base_ram_oe_n), 32'd1);
    check("rst we_n", 32'(base_ram_we_n), 32'd1);
    check("rst be_n", 32'(base_ram_be_n), 32'hF);
    check("rst addr", 32'(base_ram_addr), 32'd0);
    check("rst rdn_wrn", {30'd0, uart_rdn, uart_wrn}, 32'd3);
    check("rst stall", 32'(stall_o), 32'd0);
    check("rst if_data", if_data_o, 32'd0);
    check("rst mem_data", mem_data_o, 32'd0);
    rst_n = 1'b1;
    next_cycle();

    // SRAM fetch
    tb_bus_en = 1'b1; tb_bus_fix = 32'h12345678;
    if_ce_i = 1'b1; if_addr_i = 32'h80000010;
    measure("fetch", 20);
    check("fetch stall", 32'(m_stall), 32'd3);
    check("fetch oe_cycles", 32'(m_oe), 32'd2);
    check("fetch addr", 32'(m_addr), 32'h00004);
    check("fetch be_n", 32'(m_be), 32'h0);
    check("fetch if_data", if_data_o, 32'h12345678);
    check("fetch done oe_n", 32'(base_ram_oe_n), 32'd1);
    next_cycle();
    clear_reqs();
    tb_bus_en = 1'b0;

    // Byte write
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h80000100;
    mem_sel_i = 4'b0010; mem_data_i = 32'hAABBCCDD;
    measure("bwrite", 20);
    check("bwrite stall", 32'(m_stall), 32'd5);
    check("bwrite we_cycles", 32'(m_we), 32'd2);
    check("bwrite first_we", 32'(m_first_we), 32'd2);
    check("bwrite first_drv", 32'(m_first_drv), 32'd1);
    check("bwrite last_drv", 32'(m_last_drv), 32'd4);
    check("bwrite drv_hi", 32'(m_drv_hi), 32'd4);
    check("bwrite ce_cycles", 32'(m_ce), 32'd4);
    check("bwrite be_n", 32'(m_be), 32'b1101);
    check("bwrite addr", 32'(m_addr), 32'h00040);
    check("bwrite bus", m_bus, 32'hAABBCCDD);
    check("bwrite done hiz", {30'd0, dut.drive_hi_q, dut.drive_lo_q}, 32'd0);
    check("bwrite done we_n", 32'(base_ram_we_n), 32'd1);
    next_cycle();
    clear_reqs();

    // Write with no byte lanes still runs the full cycle
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h80000104;
    mem_sel_i = 4'b0000; mem_data_i = 32'h01020304;
    measure("sel0", 20);
    check("sel0 stall", 32'(m_stall), 32'd5);
    check("sel0 we_cycles", 32'(m_we), 32'd2);
    check("sel0 be_n", 32'(m_be), 32'hF);
    next_cycle();
    clear_reqs();

    // Simultaneous load and fetch
    tb_bus_en = 1'b1; tb_bus_by_addr = 1'b1;
    if_ce_i = 1'b1; if_addr_i = 32'h80000020;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h80000040; mem_sel_i = 4'hF;
    measure("arb_load", 20);
    check("arb_load stall", 32'(m_stall), 32'd3);
    check("arb_load addr", 32'(m_addr), 32'h00010);
    check("arb_load mem_data", mem_data_o, 32'hA5A00010);
    check("arb_load if_data kept", if_data_o, 32'h12345678);
    next_cycle();
    mem_ce_i = 1'b0;
    measure("arb_fetch", 20);
    check("arb_fetch stall", 32'(m_stall), 32'd3);
    check("arb_fetch first_ce", 32'(m_first_ce), 32'd1);
    check("arb_fetch addr", 32'(m_addr), 32'h00008);
    check("arb_fetch if_data", if_data_o, 32'hA5A00008);
    check("arb_fetch mem_data kept", mem_data_o, 32'hA5A00010);
    next_cycle();
    clear_reqs();
    tb_bus_en = 1'b0; tb_bus_by_addr = 1'b0;

    // Serial write with transmitter busy for 10 cycles
    uart_tbre = 1'b1; uart_tsre = 1'b0;
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = SER_DATA_ADDR_DEF;
    mem_sel_i = 4'h1; mem_data_i = 32'h12345641;
    fork
      measure("ser_wr", 40);
      begin
        repeat (10) @(posedge clk);
        #1 uart_tsre = 1'b1;
      end
    join
    check("ser_wr stall", 32'(m_stall), 32'd11);
    check("ser_wr wrn_cycles", 32'(m_wr), 32'd2);
    check("ser_wr first_wrn", 32'(m_first_wr), 32'd1);
    check("ser_wr byte", 32'(m_bus[7:0]), 32'h41);
    check("ser_wr ce_cycles", 32'(m_ce), 32'd0);
    check("ser_wr drv_hi", 32'(m_drv_hi), 32'd0);
    check("ser_wr drv_lo", 32'(m_drv_lo), 32'd2);
    check("ser_wr overlap", 32'(m_overlap), 32'd0);
    next_cycle();
    clear_reqs();

    // Status reads: {dataready, tbre, tsre} -> expected status word
    stat_vec[0] = 4'b0111; stat_exp[0] = 32'd3;
    stat_vec[1] = 4'b0011; stat_exp[1] = 32'd1;
    stat_vec[2] = 4'b0110; stat_exp[2] = 32'd2;
    stat_vec[3] = 4'b0001; stat_exp[3] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      uart_dataready = stat_vec[i][2]; uart_tbre = stat_vec[i][1]; uart_tsre = stat_vec[i][0];
      mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = SER_STAT_ADDR_DEF;
      measure($sformatf("stat%0d", i), 10);
      check($sformatf("stat%0d stall", i), 32'(m_stall), 32'd1);
      check($sformatf("stat%0d data", i), mem_data_o, stat_exp[i]);
      next_cycle();
      clear_reqs();
    end

    // Writes to the status address are ignored
    uart_dataready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b1;
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = SER_STAT_ADDR_DEF; mem_data_i = 32'hFFFFFFFF;
    measure("stat_wr", 10);
    check("stat_wr stall", 32'(m_stall), 32'd1);
    check("stat_wr strobes", 32'(m_ce + m_wr + m_drv_lo), 32'd0);
    check("stat_wr mem_data kept", mem_data_o, 32'd0);
    next_cycle();
    clear_reqs();

    // Serial read
    tb_bus_en = 1'b1; tb_bus_fix = 32'hFFFFFF5A;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = SER_DATA_ADDR_DEF;
    measure("ser_rd", 20);
    check("ser_rd stall", 32'(m_stall), 32'd3);
    check("ser_rd rdn_cycles", 32'(m_rd), 32'd2);
    check("ser_rd ce_cycles", 32'(m_ce), 32'd0);
    check("ser_rd data", mem_data_o, 32'h0000005A);
    next_cycle();
    clear_reqs();
    tb_bus_en = 1'b0;

    // Asynchronous reset in the middle of a write pulse
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h80000200;
    mem_sel_i = 4'hF; mem_data_i = 32'h0F0F0F0F;
    begin
      bit seen_we;
      seen_we = 1'b0;
      for (int i = 0; i < 10 && !seen_we; i++) begin
        @(negedge clk);
        if (!base_ram_we_n) seen_we = 1'b1;
      end
      check("rstmid reached_we", 32'(seen_we), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    check("rstmid we_n", 32'(base_ram_we_n), 32'd1);
    check("rstmid ce_n", 32'(base_ram_ce_n), 32'd1);
    check("rstmid hiz", {30'd0, dut.drive_hi_q, dut.drive_lo_q}, 32'd0);
    check("rstmid stall", 32'(stall_o), 32'd0);
    $display("rstmid: we_n=%b ce_n=%b stall=%b", base_ram_we_n, base_ram_ce_n, stall_o);
    next_cycle();
    clear_reqs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    check("rstmid stall_after", 32'(stall_o), 32'd0);
    next_cycle();

    // Normal read after reset recovery
    tb_bus_en = 1'b1; tb_bus_fix = 32'hCAFEF00D;
    if_ce_i = 1'b1; if_addr_i = 32'h80000008;
    measure("post_rst", 20);
    check("post_rst stall", 32'(m_stall), 32'd3);
    check("post_rst if_data", if_data_o, 32'hCAFEF00D);
    next_cycle();
    clear_reqs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
